wf_rr_arbiter_2c: RTL and testbench

Parametrised two-class round-robin wavefront arbiter for the issue stage, successor to the single-class 40-entry issue arbiter.
- Picks one ready wavefront per cycle from NUM_WF request bits.
- High-priority class is served first; each class keeps its own round-robin pointer.
- Pointers advance only when the issue stage confirms an issue.
- Grant is combinational from current requests plus registered pointer state, so the issue stage sees it in the same cycle.

---
 rtl/wf_arb_pkg.sv | 14 +
 rtl/wf_rr_arbiter_2c_rr_pick.sv | 47 ++++
 rtl/wf_rr_arbiter_2c.sv | 133 +++++++++++++
 tb/tb_wf_rr_arbiter_2c.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wf_arb_pkg.sv
// Shared defaults and helpers for the two-class round-robin wavefront arbiter.
// The optional starvation guard is enabled by defining WF_ARB_STARVE_GUARD_EN.
package wf_arb_pkg;

    localparam int NUM_WF_DEF       = 40;
    localparam int WF_ID_W_DEF      = 6;
    localparam int STARVE_LIMIT_DEF = 15;

    // Exact modulo-n increment; an out-of-range id also lands on slot 0.
    function automatic int wrap_inc(input int id, input int n);
        return (id + 1 >= n) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/wf_rr_arbiter_2c_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after
// (ptr+1) mod NUM_WF, ascending with wrap.
module rr_pick
    import wf_arb_pkg::*;
#(
    parameter int NUM_WF  = NUM_WF_DEF,
    parameter int WF_ID_W = WF_ID_W_DEF
) (
    input  logic [NUM_WF-1:0]  req_i,
    input  logic [WF_ID_W-1:0] ptr_i,
    output logic               valid_o,
    output logic [WF_ID_W-1:0] id_o
);

    int                 start;
    logic               upper_found;
    logic               lower_found;
    logic [WF_ID_W-1:0] upper_id;
    logic [WF_ID_W-1:0] lower_id;

    // Two passes: slots at/after start, then the wrapped slots below start.
    // Descending scan so the lowest qualifying index is the one that sticks.
    always_comb begin
        start       = wrap_inc(int'(ptr_i), NUM_WF);
        upper_found = 1'b0;
        lower_found = 1'b0;
        upper_id    = '0;
        lower_id    = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                if (i >= start) begin
                    upper_found = 1'b1;
                    upper_id    = WF_ID_W'(i);
                end else begin
                    lower_found = 1'b1;
                    lower_id    = WF_ID_W'(i);
                end
            end
        end
    end

    always_comb begin
        valid_o = upper_found | lower_found;
        id_o    = upper_found ? upper_id : lower_id;
    end

endmodule

// File: rtl/wf_rr_arbiter_2c.sv
// Two-class round-robin wavefront arbiter with per-class pointers that follow
// confirmed issues. Optional low-class starvation guard: WF_ARB_STARVE_GUARD_EN.
module wf_rr_arbiter_2c
    import wf_arb_pkg::*;
#(
    parameter int NUM_WF       = NUM_WF_DEF,
    parameter int WF_ID_W      = WF_ID_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_WF-1:0]  req_arry,
    input  logic [NUM_WF-1:0]  req_hi_arry,
    input  logic               issued_en,
    input  logic [WF_ID_W-1:0] issued_wf_id,
    input  logic               issued_hi,
    output logic               choosen_valid,
    output logic [WF_ID_W-1:0] choosen_wf_id,
    output logic               choosen_hi
);

    localparam logic [WF_ID_W-1:0] PTR_RESET = WF_ID_W'(NUM_WF - 1);
    localparam logic [WF_ID_W:0]   NUM_WF_L  = (WF_ID_W + 1)'(NUM_WF);

    logic [NUM_WF-1:0]  hi_req;
    logic [NUM_WF-1:0]  lo_req;
    logic               lo_any;
    logic               issue_ok;
    logic               lo_force;

    logic [WF_ID_W-1:0] ptr_hi_q, ptr_hi_d;
    logic [WF_ID_W-1:0] ptr_lo_q, ptr_lo_d;

    logic               hi_valid;
    logic [WF_ID_W-1:0] hi_id;
    logic               lo_valid;
    logic [WF_ID_W-1:0] lo_id;

    assign hi_req   = req_arry & req_hi_arry;
    assign lo_req   = req_arry & ~req_hi_arry;
    assign lo_any   = |lo_req;
    assign issue_ok = issued_en && ({1'b0, issued_wf_id} < NUM_WF_L);

    rr_pick #(
        .NUM_WF  (NUM_WF),
        .WF_ID_W (WF_ID_W)
    ) u_pick_hi (
        .req_i   (hi_req),
        .ptr_i   (ptr_hi_q),
        .valid_o (hi_valid),
        .id_o    (hi_id)
    );

    rr_pick #(
        .NUM_WF  (NUM_WF),
        .WF_ID_W (WF_ID_W)
    ) u_pick_lo (
        .req_i   (lo_req),
        .ptr_i   (ptr_lo_q),
        .valid_o (lo_valid),
        .id_o    (lo_id)
    );

    // Grant is gated to zero while reset is held, whatever the requests.
    always_comb begin
        choosen_valid = 1'b0;
        choosen_wf_id = '0;
        choosen_hi    = 1'b0;
        if (rst) begin
            if (hi_valid && !lo_force) begin
                choosen_valid = 1'b1;
                choosen_wf_id = hi_id;
                choosen_hi    = 1'b1;
            end else if (lo_valid) begin
                choosen_valid = 1'b1;
                choosen_wf_id = lo_id;
                choosen_hi    = 1'b0;
            end
        end
    end

    // Pointers track what the issue stage actually issued, not the grant.
    always_comb begin
        ptr_hi_d = ptr_hi_q;
        ptr_lo_d = ptr_lo_q;
        if (issue_ok) begin
            if (issued_hi) begin
                ptr_hi_d = issued_wf_id;
            end else begin
                ptr_lo_d = issued_wf_id;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_hi_q <= PTR_RESET;
            ptr_lo_q <= PTR_RESET;
        end else begin
            ptr_hi_q <= ptr_hi_d;
            ptr_lo_q <= ptr_lo_d;
        end
    end

`ifdef WF_ARB_STARVE_GUARD_EN
    localparam int                 CNT_W      = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]   STARVE_MAX = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    assign lo_force = (starve_cnt_q == STARVE_MAX) && lo_any;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lo_any || (issue_ok && !issued_hi)) begin
            starve_cnt_d = '0;
        end else if (choosen_hi && issue_ok && issued_hi && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign lo_force = 1'b0;
`endif

endmodule

// File: tb/tb_wf_rr_arbiter_2c.sv
// Self-checking bench for wf_rr_arbiter_2c: directed scenarios then random
// traffic, compared against a modulo-arithmetic reference model.
module tb_wf_rr_arbiter_2c;

    localparam int NUM_WF       = 40;
    localparam int WF_ID_W      = 6;
    localparam int STARVE_LIMIT = 15;

    logic               clk;
    logic               rst;
    logic [NUM_WF-1:0]  req_arry;
    logic [NUM_WF-1:0]  req_hi_arry;
    logic               issued_en;
    logic [WF_ID_W-1:0] issued_wf_id;
    logic               issued_hi;
    logic               choosen_valid;
    logic [WF_ID_W-1:0] choosen_wf_id;
    logic               choosen_hi;

    int vectors;
    int miscompares;

    // Reference model state
    int   m_ptr_hi;
    int   m_ptr_lo;
    int   m_cnt;
    logic e_v;
    int   e_id;
    logic e_h;

    wf_rr_arbiter_2c #(
        .NUM_WF       (NUM_WF),
        .WF_ID_W      (WF_ID_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_arry      (req_arry),
        .req_hi_arry   (req_hi_arry),
        .issued_en     (issued_en),
        .issued_wf_id  (issued_wf_id),
        .issued_hi     (issued_hi),
        .choosen_valid (choosen_valid),
        .choosen_wf_id (choosen_wf_id),
        .choosen_hi    (choosen_hi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [NUM_WF-1:0] m, input int ptr);
        for (int k = 1; k <= NUM_WF; k++) begin
            int id;
            id = (ptr + k) % NUM_WF;
            if (m[id]) return id;
        end
        return 0;
    endfunction

    task automatic compute_expect();
        logic [NUM_WF-1:0] hm;
        logic [NUM_WF-1:0] lm;
        logic              starved;
        hm = req_arry & req_hi_arry;
        lm = req_arry & ~req_hi_arry;
        starved = 1'b0;
`ifdef WF_ARB_STARVE_GUARD_EN
        starved = (m_cnt == STARVE_LIMIT) && (lm != '0);
`endif
        e_v = 1'b0; e_id = 0; e_h = 1'b0;
        if (rst) begin
            if (hm != '0 && !starved) begin
                e_v = 1'b1; e_id = pick(hm, m_ptr_hi); e_h = 1'b1;
            end else if (lm != '0) begin
                e_v = 1'b1; e_id = pick(lm, m_ptr_lo); e_h = 1'b0;
            end
        end
    endtask

    // Check the combinational grant, then clock once and advance the model.
    task automatic step(input string tag);
        logic [WF_ID_W+1:0] exp_vec;
        logic               ok;
        #1;
        compute_expect();
        exp_vec = {e_v, WF_ID_W'(e_id), e_h};
        vectors++;
        assert ({choosen_valid, choosen_wf_id, choosen_hi} === exp_vec)
        else begin
            miscompares++;
            $error("FAIL %s: got v=%0b id=%0d hi=%0b, expected v=%0b id=%0d hi=%0b",
                   tag, choosen_valid, choosen_wf_id, choosen_hi, e_v, e_id, e_h);
        end
        @(posedge clk);
        if (!rst) begin
            m_ptr_hi = NUM_WF - 1;
            m_ptr_lo = NUM_WF - 1;
            m_cnt    = 0;
        end else begin
            ok = issued_en && (int'(issued_wf_id) < NUM_WF);
`ifdef WF_ARB_STARVE_GUARD_EN
            if (((req_arry & ~req_hi_arry) == '0) || (ok && !issued_hi)) m_cnt = 0;
            else if (e_h && ok && issued_hi && m_cnt < STARVE_LIMIT) m_cnt++;
`endif
            if (ok) begin
                if (issued_hi) m_ptr_hi = int'(issued_wf_id);
                else           m_ptr_lo = int'(issued_wf_id);
            end
        end
        @(negedge clk);
    endtask

    task automatic set_issue(input logic en, input int id, input logic hi);
        issued_en    = en;
        issued_wf_id = WF_ID_W'(id);
        issued_hi    = hi;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr_hi    = NUM_WF - 1;
        m_ptr_lo    = NUM_WF - 1;
        m_cnt       = 0;
        rst         = 1'b0;
        req_arry    = '1;
        req_hi_arry = '0;
        set_issue(1'b0, 0, 1'b0);

        // Reset: outputs gated low despite requests
        step("reset0");
        step("reset1");
        rst = 1'b1;

        // Low-class sweep 0..39 then wrap back to 0
        for (int i = 0; i < NUM_WF; i++) begin
            set_issue(1'b1, i, 1'b0);
            step($sformatf("sweep%0d", i));
        end
        set_issue(1'b0, 0, 1'b0);
        step("sweep_wrap");

        // High class wins; high issue leaves low pointer alone
        req_arry = '0; req_arry[3] = 1'b1; req_arry[20] = 1'b1;
        req_hi_arry = '0; req_hi_arry[20] = 1'b1;
        set_issue(1'b1, 20, 1'b1);
        step("hi_first");
        set_issue(1'b0, 0, 1'b0);
        step("hi_repeat");
        req_arry[20] = 1'b0;
        step("lo_after_hi_drop");

        // Low pointer at 10 with requests {5,10,12}
        req_arry = '0; req_hi_arry = '0;
        set_issue(1'b1, 10, 1'b0);
        step("idle_set_ptr10");
        req_arry[5] = 1'b1; req_arry[10] = 1'b1; req_arry[12] = 1'b1;
        set_issue(1'b1, 12, 1'b0);
        step("rr_12");
        set_issue(1'b1, 5, 1'b0);
        step("rr_5");
        set_issue(1'b0, 0, 1'b0);
        step("rr_10");

        // Out-of-range issue id is ignored
        set_issue(1'b1, 45, 1'b0);
        step("oob_issue");
        set_issue(1'b0, 0, 1'b0);
        step("oob_hold");

        // No requests, then reset mid-stream with an issue (reset wins)
        req_arry = '0;
        step("no_req");
        req_arry[9] = 1'b1; req_arry[30] = 1'b1;
        step("pre_reset");
        rst = 1'b0;
        set_issue(1'b1, 30, 1'b0);
        step("mid_reset0");
        step("mid_reset1");
        rst = 1'b1;
        set_issue(1'b0, 0, 1'b0);
        step("post_reset_lowest");

        // Persistent high requester vs waiting low requester
        req_arry = '0; req_hi_arry = '0;
        req_arry[1] = 1'b1; req_hi_arry[1] = 1'b1; req_arry[7] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            compute_expect();
            set_issue(1'b1, e_id, e_h);
            step($sformatf("starve%0d", i));
        end
        set_issue(1'b0, 0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            case ($urandom_range(0, 3))
                0:       req_arry = '0;
                1:       req_arry = NUM_WF'({$urandom, $urandom}) & NUM_WF'({$urandom, $urandom});
                default: req_arry = NUM_WF'({$urandom, $urandom});
            endcase
            req_hi_arry = NUM_WF'({$urandom, $urandom});
            compute_expect();
            if (e_v && $urandom_range(0, 9) < 6)
                set_issue(1'b1, e_id, e_h);
            else
                set_issue(($urandom_range(0, 1) == 1), $urandom_range(0, 63), ($urandom_range(0, 1) == 1));
            step($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
